// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared FSM states, ALU control codes and MIPS opcode/funct constants
package mips_cpu_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_AND  = 4'b0000;
  localparam alu_op_t ALU_OR   = 4'b0001;
  localparam alu_op_t ALU_XOR  = 4'b0010;
  localparam alu_op_t ALU_LUI  = 4'b0011;
  localparam alu_op_t ALU_ADDU = 4'b0100;
  localparam alu_op_t ALU_SUBU = 4'b0101;
  localparam alu_op_t ALU_SLTU = 4'b0110;
  localparam alu_op_t ALU_JR   = 4'b0111;
  localparam alu_op_t ALU_SLL  = 4'b1000;
  localparam alu_op_t ALU_SRL  = 4'b1001;
  localparam alu_op_t ALU_SLLV = 4'b1010;
  localparam alu_op_t ALU_SRLV = 4'b1011;
  localparam alu_op_t ALU_SRA  = 4'b1100;
  localparam alu_op_t ALU_SRAV = 4'b1101;
  localparam alu_op_t ALU_SLT  = 4'b1110;
  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
  localparam logic [5:0] OPCODE_ADDIU   = 6'h09;
  localparam logic [5:0] OPCODE_SLTI    = 6'h0A;
  localparam logic [5:0] OPCODE_SLTIU   = 6'h0B;
  localparam logic [5:0] OPCODE_ANDI    = 6'h0C;
  localparam logic [5:0] OPCODE_ORI     = 6'h0D;
  localparam logic [5:0] OPCODE_XORI    = 6'h0E;
  localparam logic [5:0] OPCODE_LUI     = 6'h0F;
  localparam logic [5:0] OPCODE_LW      = 6'h23;
  localparam logic [5:0] OPCODE_SW      = 6'h2B;
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;
endpackage

// File: rtl/mips_cpu_decoder.sv
// mips_cpu_decoder: combinational opcode/funct decode into ALU control, immediate and write-address select
// in: opcode, funct, imm (instr[15:0]); out: alu_control, imm_ext, alu_b_sel, reg_dst (1 = rd), illegal
module mips_cpu_decoder
  import mips_cpu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output alu_op_t     alu_control,
  output logic [31:0] imm_ext,
  output logic        alu_b_sel,
  output logic        reg_dst,
  output logic        illegal
);
  logic zero_ext;
  always_comb begin
    alu_control = ALU_AND;
    zero_ext = 1'b0;
    alu_b_sel = 1'b1;
    reg_dst = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPCODE_SPECIAL: begin
        alu_b_sel = 1'b0;
        reg_dst = 1'b1;
        case (funct)
          FUNCT_ADDU: alu_control = ALU_ADDU;
          FUNCT_SUBU: alu_control = ALU_SUBU;
          FUNCT_AND:  alu_control = ALU_AND;
          FUNCT_OR:   alu_control = ALU_OR;
          FUNCT_XOR:  alu_control = ALU_XOR;
          FUNCT_SLT:  alu_control = ALU_SLT;
          FUNCT_SLTU: alu_control = ALU_SLTU;
          FUNCT_SLL:  alu_control = ALU_SLL;
          FUNCT_SRL:  alu_control = ALU_SRL;
          FUNCT_SRA:  alu_control = ALU_SRA;
          FUNCT_SLLV: alu_control = ALU_SLLV;
          FUNCT_SRLV: alu_control = ALU_SRLV;
          FUNCT_SRAV: alu_control = ALU_SRAV;
          FUNCT_JR:   alu_control = ALU_JR;
          default:    illegal = 1'b1;
        endcase
      end
      OPCODE_ADDIU, OPCODE_LW, OPCODE_SW: alu_control = ALU_ADDU;
      OPCODE_SLTI:  alu_control = ALU_SLT;
      OPCODE_SLTIU: alu_control = ALU_SLTU;
      OPCODE_ANDI: begin
        alu_control = ALU_AND;
        zero_ext = 1'b1;
      end
      OPCODE_ORI: begin
        alu_control = ALU_OR;
        zero_ext = 1'b1;
      end
      OPCODE_XORI: begin
        alu_control = ALU_XOR;
        zero_ext = 1'b1;
      end
      OPCODE_LUI: begin
        alu_control = ALU_LUI;
        zero_ext = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end
  assign imm_ext = zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
endmodule

// File: rtl/mips_cpu_control.sv
// mips_cpu_control: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the PC and jr delay slot
// bus: mem_address/read/write/waitrequest/readdata; alu: alu_control/sa/b_sel, imm_ext, alu_r;
// regfile: rs/rt_addr, rs_data, reg_write_en/addr, wb_sel; status: pc, active
module mips_cpu_control
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [3:0]  alu_control,
  output logic [4:0]  alu_sa,
  output logic        alu_b_sel,
  output logic [31:0] imm_ext,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] alu_r,
  output logic        reg_write_en,
  output logic [4:0]  reg_write_addr,
  output logic        wb_sel,
  output logic [31:0] pc,
  output logic        active
);
  state_t state, state_next;
  logic [31:0] instr, jr_target, pc_next;
  logic jr_pending, reg_dst, illegal, is_lw, is_sw, is_jr;
  alu_op_t dec_control;
  mips_cpu_decoder u_dec (
    .opcode(instr[31:26]),
    .funct(instr[5:0]),
    .imm(instr[15:0]),
    .alu_control(dec_control),
    .imm_ext(imm_ext),
    .alu_b_sel(alu_b_sel),
    .reg_dst(reg_dst),
    .illegal(illegal)
  );
  assign is_lw = instr[31:26] == OPCODE_LW;
  assign is_sw = instr[31:26] == OPCODE_SW;
  assign is_jr = instr[31:26] == OPCODE_SPECIAL && instr[5:0] == FUNCT_JR;
  // a pending jr redirects the PC after its delay slot retires
  assign pc_next = jr_pending ? jr_target : pc + 32'd4;
  assign rs_addr = instr[25:21];
  assign rt_addr = instr[20:16];
  assign alu_sa = instr[10:6];
  assign alu_control = state inside {DECODE, EXEC, MEM, WB} ? dec_control : ALU_AND;
  assign mem_address = state == MEM ? alu_r : pc;
  // reset gates the read strobe combinationally so it drops the moment reset rises
  assign mem_read = !reset && (state == FETCH || (state == MEM && is_lw));
  assign mem_write = !reset && state == MEM && is_sw;
  assign reg_write_en = state == WB && !is_sw && !is_jr;
  assign reg_write_addr = reg_dst ? instr[15:11] : instr[20:16];
  assign wb_sel = is_lw;
  assign active = state != HALT;
  always_comb begin
    state_next = state;
    case (state)
      FETCH:   state_next = mem_waitrequest ? FETCH : DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = illegal ? HALT : (is_lw || is_sw) ? MEM : WB;
      MEM:     state_next = mem_waitrequest ? MEM : WB;
      WB:      state_next = pc_next == 32'h0 ? HALT : FETCH;
      default: state_next = HALT;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_VECTOR;
      instr <= 32'h0;
      jr_pending <= 1'b0;
      jr_target <= 32'h0;
    end else begin
      state <= state_next;
      if (state == FETCH && !mem_waitrequest) instr <= mem_readdata;
      if (state == WB) begin
        pc <= pc_next;
        jr_pending <= is_jr;
        if (is_jr) jr_target <= rs_data;
      end
    end
  end
endmodule

// File: tb/tb_mips_cpu_control.sv
// tb_mips_cpu_control: scoreboard bench; expected bus/decode/writeback events are queued, a monitor pops and compares
module tb_mips_cpu_control;
  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] DADDR = 32'h00002000;
  localparam int KF = 0, KD = 1, KM = 2, KW = 3;
  logic clk = 0, reset = 0, mem_waitrequest = 0;
  logic [31:0] mem_address, mem_readdata, imm_ext, rs_data, pc;
  logic [31:0] alu_r = DADDR;
  logic mem_read, mem_write, alu_b_sel, reg_write_en, wb_sel, active;
  logic [3:0] alu_control;
  logic [4:0] alu_sa, rs_addr, rt_addr, reg_write_addr;
  int phase = 0;
  int errors = 0, checks = 0;
  typedef struct {int kind; logic [31:0] a; logic [31:0] b; int dc;} ev_t;
  ev_t sb[$];
  string nm[4] = '{"fetch", "decode", "mem", "wb"};

  mips_cpu_control dut (
    .clk(clk), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .alu_control(alu_control), .alu_sa(alu_sa), .alu_b_sel(alu_b_sel), .imm_ext(imm_ext),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .alu_r(alu_r),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr), .wb_sel(wb_sel),
    .pc(pc), .active(active)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(int ph, logic [31:0] a);
    if (ph == 1) return a == RV ? 32'hFC000000 : 32'h0;
    if (ph == 2) return a == RV ? 32'h8C410004 : 32'h0;
    case (a)
      32'hBFC00000: return 32'h00430821;
      32'hBFC00004: return 32'h8C410004;
      32'hBFC00008: return 32'h34058001;
      32'hBFC0000C: return 32'h2406FFFF;
      32'hBFC00010: return 32'hAC430008;
      32'hBFC00014: return 32'h3C07F000;
      32'hBFC00018: return 32'h00034103;
      32'hBFC0001C: return 32'h0022482A;
      32'hBFC00020: return 32'h00400008;
      32'hBFC00024: return 32'h00225026;
      32'h00000100: return 32'h00800008;
      32'h00000104: return 32'h00A00008;
      default:      return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] regval(logic [4:0] r);
    case (r)
      5'd2:    return 32'h00000100;
      5'd3:    return 32'h00000033;
      5'd4:    return 32'h00000200;
      default: return 32'h0;
    endcase
  endfunction

  assign mem_readdata = rom(phase, mem_address);
  assign rs_data = regval(rs_addr);

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic pf(logic [31:0] addr);
    sb.push_back('{KF, addr, 32'd0, 0});
  endtask
  task automatic pd(logic [4:0] sa, logic [3:0] ctl, logic b, logic [31:0] imm, int dc);
    sb.push_back('{KD, {22'd0, sa, ctl, b}, imm, dc});
  endtask
  task automatic pm(logic w);
    sb.push_back('{KM, DADDR, {31'd0, w}, 0});
  endtask
  task automatic pw(logic [4:0] r, logic ws);
    sb.push_back('{KW, {27'd0, r}, {31'd0, ws}, 0});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: classifies DUT activity into events; a strobe two cycles after decode is a MEM access
  bit dec_next = 0, in_mem = 0, got;
  int age = 3, k;
  logic [31:0] a, b;
  ev_t e;
  always @(negedge clk) begin
    got = 0;
    if (reset) begin
      dec_next = 0;
      in_mem = 0;
      age = 3;
    end else begin
      if (age < 3) age++;
      if ((mem_read || mem_write) && age == 2) in_mem = 1;
      if (reg_write_en) begin
        got = 1; k = KW; a = {27'd0, reg_write_addr}; b = {31'd0, wb_sel};
      end else if (dec_next) begin
        got = 1; k = KD; a = {22'd0, alu_sa, alu_control, alu_b_sel}; b = imm_ext;
        dec_next = 0; age = 0;
      end else if ((mem_read || mem_write) && !mem_waitrequest) begin
        got = 1; k = in_mem ? KM : KF; a = mem_address; b = {31'd0, mem_write};
        dec_next = !in_mem; in_mem = 0;
      end
    end
    if (got) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected %s event: a=%h b=%h, none expected", nm[k], a, b);
      end else begin
        e = sb.pop_front();
        chk("event kind", k, e.kind);
        if (k == e.kind && e.dc != 1) begin
          chk({nm[k], " a"}, a, e.a);
          if (e.dc != 2) chk({nm[k], " b"}, b, e.b);
        end
      end
    end
  end

  task automatic drain(string n);
    int i = 0;
    while (sb.size() != 0 && i < 500) begin
      tick();
      i++;
    end
    chk(n, sb.size(), 0);
  endtask

  task automatic reach_mem(string n);
    int i = 0;
    while (!(mem_read && mem_address == DADDR) && i < 200) begin
      tick();
      i++;
    end
    chk(n, 32'(i < 200), 1);
  endtask

  initial begin
    #1 reset = 1;
    tick();
    tick();
    chk("reset mem_read", 32'(mem_read), 0);
    chk("reset pc", pc, RV);
    chk("reset active", 32'(active), 1);
    chk("reset alu_control", 32'(alu_control), 0);
    chk("reset reg_write_en", 32'(reg_write_en), 0);
    pf(RV);           pd(0, 4'b0100, 0, 32'h00000821, 2); pw(1, 0);
    pf(RV + 4);       pd(0, 4'b0100, 1, 32'h00000004, 0); pm(0); pw(1, 1);
    pf(RV + 8);       pd(0, 4'b0001, 1, 32'h00008001, 0); pw(5, 0);
    pf(RV + 12);      pd(31, 4'b0100, 1, 32'hFFFFFFFF, 0); pw(6, 0);
    pf(RV + 16);      pd(0, 4'b0100, 1, 32'h00000008, 0); pm(1);
    pf(RV + 20);      pd(0, 4'b0011, 1, 32'h0000F000, 0); pw(7, 0);
    pf(RV + 24);      pd(4, 4'b1100, 0, 32'h0, 2); pw(8, 0);
    pf(RV + 28);      pd(0, 4'b1110, 0, 32'h0, 2); pw(9, 0);
    pf(RV + 32);      pd(0, 4'b0111, 0, 32'h0, 2);
    pf(RV + 36);      pd(0, 4'b0010, 0, 32'h0, 2); pw(10, 0);
    pf(32'h100);      pd(0, 4'b0111, 0, 32'h0, 2);
    pf(32'h104);      pd(0, 4'b0111, 0, 32'h0, 2);
    pf(32'h200);      pd(0, 4'b1000, 0, 32'h0, 2); pw(0, 0);
    reset = 0;
    #1;
    chk("cycle0 mem_read", 32'(mem_read), 1);
    chk("cycle0 mem_address", mem_address, RV);
    reach_mem("lw reaches MEM");
    mem_waitrequest = 1;
    for (int i = 0; i < 3; i++) begin
      chk("lw stall address", mem_address, DADDR);
      chk("lw stall read", 32'(mem_read), 1);
      tick();
    end
    chk("lw stall end address", mem_address, DADDR);
    mem_waitrequest = 0;
    drain("program drained");
    repeat (3) tick();
    chk("jr0 halt active", 32'(active), 0);
    chk("jr0 halt mem_read", 32'(mem_read), 0);
    chk("jr0 halt mem_write", 32'(mem_write), 0);
    chk("jr0 halt reg_write_en", 32'(reg_write_en), 0);
    chk("jr0 halt pc", pc, 32'h0);
    phase = 1;
    reset = 1;
    #1;
    chk("rereset pc", pc, RV);
    chk("rereset active", 32'(active), 1);
    pf(RV);
    pd(0, 4'b0000, 0, 32'h0, 1);
    tick();
    reset = 0;
    drain("illegal drained");
    repeat (3) tick();
    chk("illegal halt active", 32'(active), 0);
    chk("illegal halt mem_read", 32'(mem_read), 0);
    reset = 1;
    #1;
    chk("illegal reset pc", pc, RV);
    chk("illegal reset active", 32'(active), 1);
    phase = 2;
    pf(RV);
    pd(0, 4'b0100, 1, 32'h00000004, 0);
    tick();
    reset = 0;
    reach_mem("midmem lw reaches MEM");
    mem_waitrequest = 1;
    tick();
    chk("midmem read held", 32'(mem_read), 1);
    #2 reset = 1;
    #1;
    chk("midmem reset mem_read", 32'(mem_read), 0);
    chk("midmem reset pc", pc, RV);
    chk("midmem queue empty", sb.size(), 0);
    mem_waitrequest = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
